rf_write_demux: RTL

Write-side counterpart of the register-file read multiplexers. It accepts write requests (address, data) and stages them for one cycle. It then decodes the address to a one-hot load strobe and commits the data into one of NUM_REGS internal registers. All register contents are exported in parallel so the existing read-port multiplexer trees can select from them.

---
 rtl/rf_write_demux_pkg.sv | 15 +
 rtl/rf_write_demux_if.sv | 29 ++
 rtl/rf_addr_decoder.sv | 24 ++
 rtl/rf_write_demux.sv | 83 ++++++++
 4 files changed

// File: rtl/rf_write_demux_pkg.sv
// rf_write_demux_pkg: shared defaults and register-index constants for the register-file write path.
package rf_write_demux_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_ZERO_REG   = 1;
    localparam int ZERO_REG_IDX   = 0;

    // An index addresses a real register only below the implemented count.
    function automatic logic addr_in_range(input logic [31:0] addr, input int num_regs);
        return addr < 32'(num_regs);
    endfunction

endpackage

// File: rtl/rf_write_demux_if.sv
// rf_write_demux_if: write request bus plus parallel register export of the register-file write path.
interface rf_write_demux_if
    import rf_write_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
);
    logic                           wr_req;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           wr_hold;
    logic                           wr_rdy;
    logic                           wr_ack;
    logic                           wr_err;
    logic [NUM_REGS-1:0]            ld_stb;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_q;

    modport master (
        output wr_req, wr_addr, wr_data, wr_hold,
        input  wr_rdy, wr_ack, wr_err, ld_stb, reg_q
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_hold,
        output wr_rdy, wr_ack, wr_err, ld_stb, reg_q
    );

endinterface

// File: rtl/rf_addr_decoder.sv
// rf_addr_decoder: enabled address-to-one-hot decoder built as an and/not chain per output.
module rf_addr_decoder
    import rf_write_demux_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    output logic [NUM_REGS-1:0]   onehot
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);
        logic [ADDR_WIDTH:0] term;
        assign term[0] = en;
        // Each stage ANDs in the true or inverted address bit matching this output's index.
        for (genvar b = 0; b < ADDR_WIDTH; b++) begin : g_bit
            assign term[b+1] = term[b] & (IDX[b] ? addr[b] : ~addr[b]);
        end
        assign onehot[i] = term[ADDR_WIDTH];
    end

endmodule

// File: rtl/rf_write_demux.sv
// rf_write_demux: stages write requests one cycle, decodes to a load strobe and commits into the register file.
module rf_write_demux
    import rf_write_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ZERO_REG   = DEF_ZERO_REG
) (
    input  logic            clk,
    input  logic            rst,
    rf_write_demux_if.slave bus
);

    localparam logic [ADDR_WIDTH:0]   LIMIT    = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG_IDX);

    logic                  stg_valid;
    logic [ADDR_WIDTH-1:0] stg_addr;
    logic [DATA_WIDTH-1:0] stg_data;
    logic                  accept;
    logic                  commit;
    logic                  out_of_range;
    logic                  zero_target;
    logic                  ack;
    logic                  err;

    assign bus.wr_rdy   = !rst && (!stg_valid || !bus.wr_hold);
    assign accept       = bus.wr_req && bus.wr_rdy;
    assign commit       = stg_valid && !bus.wr_hold;
    assign out_of_range = {1'b0, stg_addr} >= LIMIT;
    assign zero_target  = (ZERO_REG != 0) && (stg_addr == ZERO_IDX);
    assign bus.wr_ack   = ack;
    assign bus.wr_err   = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else if (accept) begin
            stg_valid <= 1'b1;
            stg_addr  <= bus.wr_addr;
            stg_data  <= bus.wr_data;
        end else if (commit) begin
            stg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
            err <= 1'b0;
        end else begin
            ack <= commit;
            err <= commit && out_of_range;
        end
    end

    // Discarded writes (hardwired zero register, unimplemented index) simply never enable the decoder.
    rf_addr_decoder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_dec (
        .addr  (stg_addr),
        .en    (commit && !out_of_range && !zero_target),
        .onehot(bus.ld_stb)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] q;
        if (ZERO_REG != 0 && i == ZERO_REG_IDX) begin : g_zero
            assign q = '0;
        end else begin : g_flop
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= '0;
                else if (bus.ld_stb[i]) q <= stg_data;
            end
        end
        assign bus.reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end

endmodule
